// File: rtl/tdm_pkg.sv
// Shared constants and types for the 8:1 TDM launch multiplexer.
// Slot index width is tied to the lane count; this revision is fixed at eight lanes.
package tdm_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned DATA_W_DEF = 1;

  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(LANES - 1);

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  typedef logic [LANES-1:0][DATA_W_DEF-1:0] frame_t;

endpackage

// File: rtl/tdm_mux8_if.sv
// Frame input handshake plus serialized slot output of the TDM multiplexer.
// master drives frames in and watches the serial side; slave is the multiplexer.
interface tdm_mux8_if
  import tdm_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) ();

  logic [DATA_W-1:0] i0, i1, i2, i3, i4, i5, i6, i7;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] o;
  logic [SEL_W-1:0]  sel;
  logic              o_valid;
  logic              frame_sync;

  modport master (
    output i0, i1, i2, i3, i4, i5, i6, i7, in_valid,
    input  in_ready, o, sel, o_valid, frame_sync
  );

  modport slave (
    input  i0, i1, i2, i3, i4, i5, i6, i7, in_valid,
    output in_ready, o, sel, o_valid, frame_sync
  );

endinterface

// File: rtl/tdm_frame_buf.sv
// One-frame hold buffer that parks a frame accepted mid-transmission.
// The buffered frame is released at the frame boundary.
module tdm_frame_buf
  import tdm_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_i,
  input  logic                           drain_i,
  input  logic [LANES-1:0][DATA_W-1:0]   frame_i,
  output logic [LANES-1:0][DATA_W-1:0]   frame_o,
  output logic                           full_o
);

  logic [LANES-1:0][DATA_W-1:0] hold_q, hold_d;
  logic                         full_q, full_d;

  // load and drain are mutually exclusive: in_ready is low whenever a drain is due
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (load_i) begin
      hold_d = frame_i;
      full_d = 1'b1;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign frame_o = hold_q;
  assign full_o  = full_q;

endmodule

// File: rtl/tdm_mux8.sv
// 8:1 time-division multiplexer: accepts a frame of eight lanes and emits one lane per clock
// with its slot index, back-to-back across frames when the next one is already waiting.
module tdm_mux8
  import tdm_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic       clk,
  input  logic       reset,
  tdm_mux8_if.slave  bus
);

  typedef logic [LANES-1:0][DATA_W-1:0] lane_frame_t;

  lane_frame_t       in_frame, hold_frame;
  lane_frame_t       act_q, act_d;
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d, sel_inc;
  logic [DATA_W-1:0] o_q, o_d;
  logic              o_valid_q, o_valid_d;
  logic              fs_q, fs_d;
  logic              hold_full, accept, last_slot, hold_load, hold_drain;

  assign in_frame = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};

  assign bus.in_ready = !hold_full && !reset;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_slot    = (sel_q == LastSlot);
  assign sel_inc      = sel_q + 1'b1;
  assign hold_load    = accept && (state_q == StSend) && !last_slot;
  assign hold_drain   = (state_q == StSend) && last_slot && hold_full;

  tdm_frame_buf #(
    .DATA_W (DATA_W)
  ) u_frame_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .frame_i (in_frame),
    .frame_o (hold_frame),
    .full_o  (hold_full)
  );

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    sel_d     = sel_q;
    o_d       = o_q;
    o_valid_d = 1'b0;
    fs_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          act_d     = in_frame;
          o_d       = in_frame[0];
          sel_d     = '0;
          o_valid_d = 1'b1;
          fs_d      = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (!last_slot) begin
          sel_d     = sel_inc;
          o_d       = act_q[sel_inc];
          o_valid_d = 1'b1;
        end else if (hold_full) begin
          act_d     = hold_frame;
          o_d       = hold_frame[0];
          sel_d     = '0;
          o_valid_d = 1'b1;
          fs_d      = 1'b1;
        end else if (accept) begin
          // Same-edge accept at the boundary skips HOLD to avoid a gap slot
          act_d     = in_frame;
          o_d       = in_frame[0];
          sel_d     = '0;
          o_valid_d = 1'b1;
          fs_d      = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      act_q     <= '0;
      sel_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      sel_q     <= sel_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.o          = o_q;
  assign bus.sel        = sel_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.frame_sync = fs_q;

endmodule
